fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based imem requester feeding an in-order
// instruction FIFO, with redirect flush and in-flight response dropping.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     redir_valid,
    input  logic [XLEN-1:0]          redir_pc,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [XLEN-1:0]          instr_pc,
    output logic [XLEN-1:0]          instr_link,
    output logic                     pc_changed,
    output logic                     misalign,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]     r_ins [DEPTH];
    logic [XLEN-1:0] r_pcq [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic            r_pc_changed;
    logic            r_misalign;

    logic [CW:0]     w_credit;
    logic            w_grant;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_valid;
    logic [XLEN-1:0] w_redir_al;

    // Requests are only issued while queue slots cover every in-flight response.
    assign w_credit   = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req   = !RST & EN & !redir_valid
                      & (w_credit < (CW+1)'(DEPTH));
    assign w_grant    = imem_req & imem_gnt;
    assign w_drop     = imem_rvalid & (r_drop_cnt != '0);
    assign w_push     = imem_rvalid & (r_drop_cnt == '0) & !redir_valid;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & instr_ready & EN & !redir_valid;
    assign w_redir_al = {redir_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_pc_changed  <= 1'b0;
            r_misalign    <= 1'b0;
        end else if (redir_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc    <= w_redir_al;
            r_resp_pc     <= w_redir_al;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_outstanding <= r_outstanding - CW'(imem_rvalid);
            r_drop_cnt    <= r_outstanding - CW'(imem_rvalid);
            r_pc_changed  <= 1'b1;
            r_misalign    <= |redir_pc[1:0];
        end else begin
            r_pc_changed  <= 1'b0;
            r_misalign    <= 1'b0;
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + XLEN'(4);
                r_wptr    <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_ins[r_wptr] <= imem_rdata;
            r_pcq[r_wptr] <= r_resp_pc;
        end
    end

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? r_ins[r_rptr] : 32'h0;
    assign instr_pc    = w_valid ? r_pcq[r_rptr] : '0;
    assign instr_link  = w_valid ? r_pcq[r_rptr] + XLEN'(4) : '0;
    assign pc_changed  = r_pc_changed;
    assign misalign    = r_misalign;
    assign occupancy   = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: latency-programmable memory model plus an
// expected-instruction scoreboard filled at grant time, drained at pop time.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_link;
    logic        pc_changed;
    logic        misalign;
    logic [2:0]  occupancy;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_link  (instr_link),
        .pc_changed  (pc_changed),
        .misalign    (misalign),
        .occupancy   (occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_gnt = 0;
    int          n_pop = 0;
    int          n_rd = 0;
    int          n_pcc = 0;
    int          n_mis = 0;
    int          n_misexp = 0;
    bit          prev_rd = 1'b0;
    logic [31:0] mpc = '0;
    logic [31:0] first_pc = '0;
    logic [31:0] first_link = '0;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic en, input logic rdy, input logic g,
                         input logic rv = 1'b0,
                         input logic [31:0] rpc = 32'h0);
        exp_t e;
        @(negedge CLK);
        EN          = en;
        instr_ready = rdy;
        imem_gnt    = g;
        redir_valid = rv;
        redir_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_of(mq[0].pc);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        if (pc_changed) n_pcc++;
        if (misalign) n_mis++;
        if (prev_rd) chk("flush_occ", 32'(occupancy), 0);
        if (!instr_valid) chk("instr_zero", instr, 0);
        if (!en) chk("en0_noreq", 32'(imem_req), 0);
        if (rv) begin
            chk("redir_noreq", 32'(imem_req), 0);
            sb.delete();
            mpc = {rpc[31:2], 2'b00};
            n_rd++;
            n_pop = 0;
            if (rpc[1:0] != 2'b00) n_misexp++;
        end else begin
            if (imem_req && imem_gnt) begin
                chk("grant_addr", imem_addr, mpc);
                sb.push_back('{mpc, mem_of(mpc)});
                mpc += 32'd4;
                n_gnt++;
            end
            if (instr_valid && instr_ready && en) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr", instr, e.ins);
                    chk("instr_link", instr_link, e.pc + 32'd4);
                    if (n_pop == 0) begin
                        first_pc   = instr_pc;
                        first_link = instr_link;
                    end
                    n_pop++;
                end
            end
        end
        if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
        prev_rd = rv;
        cyc++;
    endtask

    task automatic rst_seq();
        chk("pulse_cnt", n_pcc, n_rd);
        chk("mis_cnt", n_mis, n_misexp);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_link", instr_link, 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_pcc", 32'(pc_changed), 0);
        chk("rst_mis", 32'(misalign), 0);
        chk("rst_addr", imem_addr, RESET_PC);
        mq.delete();
        sb.delete();
        mpc         = RESET_PC;
        imem_rvalid = 1'b0;
        EN          = 1'b0;
        redir_valid = 1'b0;
        prev_rd     = 1'b0;
        n_gnt       = 0;
        n_pop       = 0;
        n_rd        = 0;
        n_pcc       = 0;
        n_mis       = 0;
        n_misexp    = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        // Streaming, 1-cycle memory
        rst_seq();
        lat = 1;
        cycle(1, 1, 1);
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", imem_addr, RESET_PC);
        chk("c0_valid", 32'(instr_valid), 0);
        cycle(1, 1, 1);
        chk("c1_nobypass", 32'(instr_valid), 0);
        cycle(1, 1, 1);
        chk("c2_valid", 32'(instr_valid), 1);
        repeat (17) cycle(1, 1, 1);
        chk("stream_pops", n_pop, 18);
        repeat (3) cycle(0, 1, 1);
        chk("en0_occ", 32'(occupancy), 2);
        repeat (6) cycle(1, 1, 1);

        // Backpressure fills the queue, then drains
        rst_seq();
        lat = 1;
        repeat (8) cycle(1, 0, 1);
        chk("bp_grants", n_gnt, 4);
        chk("bp_req", 32'(imem_req), 0);
        chk("bp_occ", 32'(occupancy), 4);
        repeat (12) cycle(1, 1, 1);
        chk("bp_pops", 32'(n_pop >= 8), 1);

        // Redirect with three in flight, 3-cycle memory
        rst_seq();
        lat = 3;
        repeat (3) cycle(1, 1, 1);
        cycle(1, 1, 1, 1, 32'h100);
        repeat (12) cycle(1, 1, 1);
        chk("rd_first_pc", first_pc, 32'h100);
        chk("rd_pulse", n_pcc, 1);

        // Redirect coinciding with response and pop
        rst_seq();
        lat = 1;
        repeat (6) cycle(1, 1, 1);
        cycle(1, 1, 1, 1, 32'h40);
        chk("rd40_noval", 32'(instr_valid), 1);
        cycle(1, 1, 1);
        chk("rd40_empty", 32'(instr_valid), 0);
        repeat (8) cycle(1, 1, 1);
        chk("rd40_first", first_pc, 32'h40);

        // Misaligned target and back-to-back redirects
        cycle(1, 1, 1, 1, 32'h103);
        cycle(1, 1, 1);
        chk("mis_pulse", 32'(misalign), 1);
        chk("mis_pcc", 32'(pc_changed), 1);
        cycle(1, 1, 1);
        chk("mis_end", 32'(misalign), 0);
        chk("pcc_end", 32'(pc_changed), 0);
        repeat (6) cycle(1, 1, 1);
        chk("mis_first", first_pc, 32'h100);
        cycle(1, 1, 1, 1, 32'h200);
        cycle(1, 1, 1, 1, 32'h300);
        repeat (8) cycle(1, 1, 1);
        chk("b2b_first", first_pc, 32'h300);

        // Random stalls and redirects, 2-cycle memory
        rst_seq();
        lat = 2;
        repeat (80) cycle(1, 1'($urandom % 2), 1'($urandom % 2),
                          1'(($urandom % 12) == 0), $urandom);
        repeat (8) cycle(1, 1, 1);

        // Address wrap, then asynchronous reset mid-stream
        cycle(1, 1, 1, 1, 32'hFFFF_FFFC);
        repeat (8) cycle(1, 1, 1);
        chk("wrap_pc", first_pc, 32'hFFFF_FFFC);
        chk("wrap_link", first_link, 32'h0);
        chk("wrap_stream", 32'(instr_valid), 1);
        rst_seq();
        repeat (4) cycle(1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
